// File: rtl/vacc_readout_if.sv
// Output stream of the spectrum readout block: AXI-Stream-style beats tagged with a frame sequence.
interface vacc_readout_if #(
    parameter int DATA_WIDTH = 32,
    parameter int SEQ_WIDTH  = 16
);
    logic [DATA_WIDTH-1:0] m_tdata;
    logic                  m_tvalid;
    logic                  m_tready;
    logic                  m_tlast;
    logic [SEQ_WIDTH-1:0]  m_tuser;

    modport master (output m_tdata, m_tvalid, m_tlast, m_tuser, input m_tready);
    modport slave  (input m_tdata, m_tvalid, m_tlast, m_tuser, output m_tready);
endinterface

// File: rtl/vacc_readout.sv
// Ping-pong capture of accumulator dumps into two banks, streamed out as tagged packets.
// Full-bank contention drops the incoming dump whole and counts it.
module vacc_readout #(
    parameter int VECTOR_WIDTH = 3,
    parameter int DATA_WIDTH   = 32,
    parameter int SEQ_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_ce,
    input  logic [DATA_WIDTH-1:0]   i_data,
    input  logic                    i_we,
    input  logic [VECTOR_WIDTH-1:0] i_addr,
    vacc_readout_if.master          m_axis,
    output logic [15:0]             o_drop_count,
    output logic                    o_pending
);

    localparam int N = 2**VECTOR_WIDTH;
    localparam logic [VECTOR_WIDTH-1:0] LAST_ADDR = VECTOR_WIDTH'(N - 1);

    typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_READING} bank_st_e;
    typedef enum logic [1:0] {W_DISARMED, W_IDLE, W_FILL, W_DISCARD} wr_st_e;
    typedef enum logic [1:0] {R_IDLE, R_READ, R_DRAIN} rd_st_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  last;
        logic [SEQ_WIDTH-1:0]  user;
    } beat_t;

    bank_st_e               r_bank [2];
    bank_st_e               w_bank_nxt [2];
    logic [SEQ_WIDTH-1:0]   r_tag [2];
    logic                   r_wr_bank;
    logic                   r_rd_bank;
    logic [SEQ_WIDTH-1:0]   r_seq;
    logic [15:0]            r_drop;

    wr_st_e                 r_wst, w_wst_nxt;
    logic                   w_wr_en, w_open, w_close, w_discard;

    rd_st_e                 r_rst, w_rst_nxt;
    logic                   w_start, w_issue, w_rd_done, w_room;
    logic [VECTOR_WIDTH-1:0] r_rd_addr;

    logic [DATA_WIDTH-1:0]  r_mem [2*N];
    logic [DATA_WIDTH-1:0]  r_rd_data;
    logic                   r_rd_vld;
    logic                   r_rd_last;
    logic [SEQ_WIDTH-1:0]   r_rd_user;

    beat_t                  r_q [2];
    logic [1:0]             r_cnt;
    logic                   w_pop;
    logic [1:0]             w_cnt_mid;
    logic [2:0]             w_occ;
    beat_t                  w_push_beat;

    // Writer: ce=0 freezes the FSM and discards that cycle's inputs entirely.
    always_comb begin
        w_wst_nxt = r_wst;
        w_wr_en   = 1'b0;
        w_open    = 1'b0;
        w_close   = 1'b0;
        w_discard = 1'b0;
        if (i_ce) begin
            case (r_wst)
                W_DISARMED: if (!i_we) w_wst_nxt = W_IDLE;
                W_IDLE: begin
                    if (i_we) begin
                        if (r_bank[r_wr_bank] == B_EMPTY) begin
                            w_open    = 1'b1;
                            w_wr_en   = 1'b1;
                            w_wst_nxt = W_FILL;
                        end else begin
                            w_wst_nxt = W_DISCARD;
                        end
                    end
                end
                W_FILL: begin
                    w_wr_en = i_we;
                    if (!i_we || i_addr == LAST_ADDR) begin
                        w_close   = 1'b1;
                        w_wst_nxt = W_IDLE;
                    end
                end
                W_DISCARD: begin
                    if (!i_we || i_addr == LAST_ADDR) begin
                        w_discard = 1'b1;
                        w_wst_nxt = W_IDLE;
                    end
                end
                default: w_wst_nxt = W_IDLE;
            endcase
        end
    end

    // Reader keeps at most two beats buffered or in flight so the head never moves while stalled.
    always_comb begin
        w_rst_nxt = r_rst;
        w_start   = 1'b0;
        w_issue   = 1'b0;
        w_rd_done = 1'b0;
        case (r_rst)
            R_IDLE: begin
                if (r_bank[r_rd_bank] == B_FULL) begin
                    w_start   = 1'b1;
                    w_issue   = w_room;
                    w_rst_nxt = R_READ;
                end
            end
            R_READ: begin
                w_issue = w_room;
                if (w_room && r_rd_addr == LAST_ADDR) w_rst_nxt = R_DRAIN;
            end
            R_DRAIN: begin
                if (w_pop && r_q[0].last) begin
                    w_rd_done = 1'b1;
                    w_rst_nxt = R_IDLE;
                end
            end
            default: w_rst_nxt = R_IDLE;
        endcase
    end

    // A bank freed this cycle is still READING to the writer, so it cannot reopen until next cycle.
    always_comb begin
        w_bank_nxt[0] = r_bank[0];
        w_bank_nxt[1] = r_bank[1];
        if (w_open)    w_bank_nxt[r_wr_bank] = B_FILLING;
        if (w_close)   w_bank_nxt[r_wr_bank] = B_FULL;
        if (w_start)   w_bank_nxt[r_rd_bank] = B_READING;
        if (w_rd_done) w_bank_nxt[r_rd_bank] = B_EMPTY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wst     <= W_DISARMED;
            r_rst     <= R_IDLE;
            r_bank[0] <= B_EMPTY;
            r_bank[1] <= B_EMPTY;
        end else begin
            r_wst     <= w_wst_nxt;
            r_rst     <= w_rst_nxt;
            r_bank[0] <= w_bank_nxt[0];
            r_bank[1] <= w_bank_nxt[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_bank <= 1'b0;
            r_seq     <= '0;
            r_drop    <= '0;
            r_tag[0]  <= '0;
            r_tag[1]  <= '0;
        end else begin
            if (w_close) begin
                r_tag[r_wr_bank] <= r_seq;
                r_wr_bank        <= ~r_wr_bank;
            end
            if (w_close || w_discard) r_seq <= r_seq + SEQ_WIDTH'(1);
            if (w_discard && r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_bank <= 1'b0;
            r_rd_addr <= '0;
            r_rd_vld  <= 1'b0;
            r_rd_last <= 1'b0;
            r_rd_user <= '0;
        end else begin
            r_rd_vld <= w_issue;
            if (w_issue) begin
                r_rd_addr <= r_rd_addr + VECTOR_WIDTH'(1);
                r_rd_last <= (r_rd_addr == LAST_ADDR);
                r_rd_user <= r_tag[r_rd_bank];
            end
            if (w_rd_done) r_rd_bank <= ~r_rd_bank;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[{r_wr_bank, i_addr}] <= i_data;
        if (w_issue) r_rd_data <= r_mem[{r_rd_bank, r_rd_addr}];
    end

    assign w_pop       = (r_cnt != 2'd0) && m_axis.m_tready;
    assign w_cnt_mid   = r_cnt - {1'b0, w_pop};
    assign w_occ       = {1'b0, r_cnt} + {2'b0, r_rd_vld} - {2'b0, w_pop};
    assign w_room      = (w_occ < 3'd2);
    assign w_push_beat = {r_rd_data, r_rd_last, r_rd_user};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q[0] <= '0;
            r_q[1] <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_pop) r_q[0] <= r_q[1];
            if (r_rd_vld) begin
                if (w_cnt_mid == 2'd0) r_q[0] <= w_push_beat;
                else                   r_q[1] <= w_push_beat;
            end
            r_cnt <= w_cnt_mid + {1'b0, r_rd_vld};
        end
    end

    assign m_axis.m_tvalid = (r_cnt != 2'd0);
    assign m_axis.m_tdata  = r_q[0].data;
    assign m_axis.m_tlast  = r_q[0].last;
    assign m_axis.m_tuser  = r_q[0].user;

    assign o_drop_count = r_drop;
    assign o_pending    = (r_bank[0] == B_FULL) || (r_bank[0] == B_READING) ||
                          (r_bank[1] == B_FULL) || (r_bank[1] == B_READING);

endmodule

// File: tb/tb_vacc_readout.sv
// Directed bench for vacc_readout: captures packets at the stream port and compares them with
// hand-computed frames, including stale-bin, drop, backpressure, reset and ce-gating cases.
module tb_vacc_readout;

    localparam int VW = 3;
    localparam int DW = 32;
    localparam int SW = 16;
    localparam int N  = 8;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          ce    = 1'b0;
    logic          we    = 1'b0;
    logic [DW-1:0] din   = '0;
    logic [VW-1:0] addr  = '0;
    logic [15:0]   drop_count;
    logic          pending;

    vacc_readout_if #(.DATA_WIDTH(DW), .SEQ_WIDTH(SW)) axis ();

    vacc_readout #(.VECTOR_WIDTH(VW), .DATA_WIDTH(DW), .SEQ_WIDTH(SW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_ce         (ce),
        .i_data       (din),
        .i_we         (we),
        .i_addr       (addr),
        .m_axis       (axis),
        .o_drop_count (drop_count),
        .o_pending    (pending)
    );

    always #5 clk = ~clk;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DW-1:0] q_data [$];
    logic          q_last [$];
    logic [SW-1:0] q_user [$];
    logic [DW-1:0] ed [N];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Beat capture plus hold check: a stalled beat must be presented unchanged next cycle.
    logic        p_stall = 1'b0;
    logic [48:0] p_out   = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            p_stall = 1'b0;
        end else begin
            if (p_stall) begin
                chk("stall_tvalid", 64'(axis.m_tvalid), 64'd1);
                chk("stall_hold", 64'({axis.m_tdata, axis.m_tlast, axis.m_tuser}), 64'(p_out));
            end
            p_stall = axis.m_tvalid && !axis.m_tready;
            p_out   = {axis.m_tdata, axis.m_tlast, axis.m_tuser};
            if (axis.m_tvalid && axis.m_tready) begin
                q_data.push_back(axis.m_tdata);
                q_last.push_back(axis.m_tlast);
                q_user.push_back(axis.m_tuser);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int d);
        ce = 1'b1; we = 1'b1; addr = VW'(a); din = DW'(d);
        tick();
    endtask

    task automatic idle(input int n);
        ce = 1'b1; we = 1'b0;
        repeat (n) tick();
    endtask

    task automatic frame(input int base);
        for (int a = 0; a < N; a++) wr(a, base + a);
    endtask

    task automatic set_ed(input int base);
        for (int i = 0; i < N; i++) ed[i] = DW'(base + i);
    endtask

    task automatic clear_q();
        q_data.delete(); q_last.delete(); q_user.delete();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; ce = 1'b0; we = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        idle(1);
        clear_q();
    endtask

    task automatic wait_beats(input int n, input string tag);
        int c = 0;
        while (q_data.size() < n && c < 400) begin
            @(negedge clk);
            c++;
        end
        if (q_data.size() < n) chk({tag, "_timeout"}, 64'(q_data.size()), 64'(n));
    endtask

    task automatic wait_idle(input string tag);
        int c = 0;
        while (pending && c < 400) begin
            @(negedge clk);
            c++;
        end
        if (pending) chk({tag, "_idle_timeout"}, 64'(pending), 64'd0);
    endtask

    task automatic expect_pkt(input string tag, input logic [SW-1:0] user);
        wait_beats(N, tag);
        for (int i = 0; i < N; i++) begin
            if (q_data.size() == 0) break;
            chk($sformatf("%s_data%0d", tag, i), 64'(q_data.pop_front()), 64'(ed[i]));
            chk($sformatf("%s_last%0d", tag, i), 64'(q_last.pop_front()), 64'(i == N - 1));
            chk($sformatf("%s_user%0d", tag, i), 64'(q_user.pop_front()), 64'(user));
        end
    endtask

    initial begin
        axis.m_tready = 1'b1;
        #12;
        chk("rst_tvalid", 64'(axis.m_tvalid), 64'd0);
        chk("rst_tlast",  64'(axis.m_tlast),  64'd0);
        chk("rst_tdata",  64'(axis.m_tdata),  64'd0);
        chk("rst_tuser",  64'(axis.m_tuser),  64'd0);
        chk("rst_drop",   64'(drop_count),    64'd0);
        chk("rst_pending", 64'(pending),      64'd0);
        apply_reset();

        // 1: single frame, first tvalid two cycles after the closing write
        chk("t1_pending_pre", 64'(pending), 64'd0);
        frame(10);
        we = 1'b0;
        @(negedge clk);
        chk("t1_tvalid_c1", 64'(axis.m_tvalid), 64'd0);
        chk("t1_pending", 64'(pending), 64'd1);
        @(negedge clk);
        chk("t1_tvalid_c2", 64'(axis.m_tvalid), 64'd0);
        @(negedge clk);
        chk("t1_tvalid_c3", 64'(axis.m_tvalid), 64'd1);
        chk("t1_tdata_c3", 64'(axis.m_tdata), 64'd10);
        set_ed(10);
        expect_pkt("t1", 16'd0);
        wait_idle("t1");

        // 2: short burst closed by we drop; bins 6,7 of bank 0 still hold 16,17 from test 1
        frame(1);
        for (int a = 0; a < 6; a++) wr(a, 20 + a);
        idle(2);
        set_ed(1);
        expect_pkt("t2a", 16'd1);
        set_ed(20);
        ed[6] = 32'd16;
        ed[7] = 32'd17;
        expect_pkt("t2b", 16'd2);
        wait_idle("t2");

        // 3: stalled output, third frame finds no free bank
        apply_reset();
        axis.m_tready = 1'b0;
        frame(100);
        frame(200);
        frame(300);
        idle(3);
        chk("t3_drop", 64'(drop_count), 64'd1);
        chk("t3_pending", 64'(pending), 64'd1);
        chk("t3_tvalid_stalled", 64'(axis.m_tvalid), 64'd1);
        chk("t3_tdata_stalled", 64'(axis.m_tdata), 64'd100);
        axis.m_tready = 1'b1;
        set_ed(100);
        expect_pkt("t3a", 16'd0);
        set_ed(200);
        expect_pkt("t3b", 16'd1);
        frame(400);
        idle(1);
        set_ed(400);
        expect_pkt("t3d", 16'd3);
        chk("t3_drop_after", 64'(drop_count), 64'd1);
        wait_idle("t3");

        // 4: tready toggling every cycle
        frame(500);
        idle(1);
        for (int c = 0; c < 40; c++) begin
            axis.m_tready = c[0];
            tick();
        end
        axis.m_tready = 1'b1;
        set_ed(500);
        expect_pkt("t4", 16'd4);
        wait_idle("t4");

        // 5: reset mid-packet, burst straddling release must be ignored
        frame(600);
        idle(1);
        wait_beats(4, "t5_beats");
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_tvalid_rst", 64'(axis.m_tvalid), 64'd0);
        chk("t5_drop_rst", 64'(drop_count), 64'd0);
        for (int i = 0; i < 4; i++)
            if (q_data.size() != 0) chk($sformatf("t5_pre_data%0d", i), 64'(q_data.pop_front()), 64'(600 + i));
        clear_q();
        for (int a = 0; a < 3; a++) begin
            ce = 1'b1; we = 1'b1; addr = VW'(a); din = DW'(700 + a);
            tick();
        end
        rst_n = 1'b1;
        for (int a = 3; a < N; a++) wr(a, 700 + a);
        idle(6);
        chk("t5_no_pkt", 64'(q_data.size()), 64'd0);
        chk("t5_pending_ignored", 64'(pending), 64'd0);
        frame(800);
        idle(1);
        set_ed(800);
        expect_pkt("t5", 16'd0);
        wait_idle("t5");

        // 6: ce low for three cycles mid-frame; bins 3..5 of bank 1 keep 503..505 from test 4
        for (int a = 0; a < 3; a++) wr(a, 900 + a);
        for (int a = 3; a < 6; a++) begin
            ce = 1'b0; we = 1'b1; addr = VW'(a); din = 32'hDEAD;
            tick();
        end
        chk("t6_no_early_close", 64'(pending), 64'd0);
        wr(6, 906);
        wr(7, 907);
        idle(1);
        set_ed(900);
        ed[3] = 32'd503;
        ed[4] = 32'd504;
        ed[5] = 32'd505;
        expect_pkt("t6", 16'd1);
        wait_idle("t6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
